perceptron_mac: RTL and testbench
=================================

// Module: perceptron_mac
// PURPOSE
//  Sequential signed fixed-point multiply-accumulate neuron: streams N_INPUTS (x,w) pairs, adds bias,
//  normalises, saturates and applies a selectable activation. Successor to the single 6-bit
//  unsigned multiplier/adder datapath, generalised in width, fraction point, input count and activation.
//  Sits between the input/weight sequencer and the output layer register.
// PARAMETERS
//  WIDTH     6  data width, signed two's complement, of x, w, bias and result
//  FRAC      3  fractional bits (Q(WIDTH-FRAC).FRAC); 0 <= FRAC < WIDTH
//  N_INPUTS  4  pairs per neuron evaluation; >= 1
//  ACT       0  activation: 0 identity, 1 ReLU, 2 step
// PORTS
//  clk        in   1      clock, all state on posedge
//  reset      in   1      synchronous, active-high
//  start      in   1      begin evaluation; sampled only in IDLE
//  bias       in   WIDTH  bias; captured on accepted start
//  in_valid   in   1      x/w pair valid
//  in_ready   out  1      block accepts a pair this cycle
//  x          in   WIDTH  input activation
//  w          in   WIDTH  weight
//  out_valid  out  1      result valid; held until out_ready
//  out_ready  in   1      downstream takes result
//  result     out  WIDTH  activated, saturated output
//  fire       out  1      1 when normalised pre-activation sum > 0
//  sat        out  1      1 when the pre-activation sum saturated
// BEHAVIOUR
//  Reset: state IDLE, acc=0, count=0, in_ready=0, out_valid=0, result=0, fire=0, sat=0.
//  Reset in any state aborts the evaluation; partial sums are discarded.
//  FSM IDLE -> ACCUM -> NORM -> DONE -> IDLE.
//   IDLE:  start=1 -> acc<=bias<<<FRAC (sign-extended), count<=0, bias latched, -> ACCUM.
//   ACCUM: in_ready=1. Beat = in_valid&in_ready: acc<=acc+x*w (full 2*WIDTH signed product),
//          count++. Beat with count==N_INPUTS-1 -> NORM. No beat: hold.
//   NORM:  in_ready=0; s = acc>>>FRAC (arithmetic, truncation toward -inf); clamp s to
//          [-2^(WIDTH-1), 2^(WIDTH-1)-1]; sat<=clamped; fire<=(s>0);
//          result<= ACT0: clamp(s); ACT1: max(clamp(s),0); ACT2: fire ? (1<<FRAC) : 0. -> DONE.
//   DONE:  out_valid=1, result/fire/sat stable. out_ready=1 -> IDLE, out_valid=0 next cycle.
//  acc width: 2*WIDTH + clog2(N_INPUTS+1) + 1 bits; never overflows internally.
//  Latency: last beat accepted at cycle T -> out_valid high at T+2.
//  start outside IDLE ignored (incl. the DONE->IDLE handshake cycle). in_valid outside ACCUM ignored.
//  N_INPUTS=1: single beat goes straight to NORM. result/fire/sat persist after DONE until next NORM.
// TESTING (WIDTH=6, FRAC=3, N_INPUTS=4)
//  Basic: bias=0, x={8,8,0,0} w={4,4,5,7} -> result=8 (1.0), fire=1, sat=0, out_valid 2 cyc after beat 4.
//  Saturate: bias=0, x=w=8 x4 -> sum 4.0 -> result=31, sat=1; negated w=-8 -> result=-32, sat=0.
//  Truncation/bias: x=w=1 x4, bias=-1 -> acc=-4 -> s=-1 -> result=-1 (ACT0), 0 (ACT1), fire=0.
//  Step: ACT=2, bias=1, x=0 -> result=8, fire=1; bias=0 -> result=0.
//  Flow control: random in_valid gaps and out_ready stalled 5 cycles -> same result, held stable,
//   start pulses during ACCUM/DONE ignored.
//  Reset mid-ACCUM after 2 beats -> IDLE, outputs zero; new evaluation unaffected by old partials.

Source files
------------

// File: rtl/perceptron_mac_if.sv
// Handshake bundle between the input/weight sequencer, the neuron and the
// output layer register. The sequencer side is the master; the neuron is
// the slave.
interface perceptron_mac_if #(
   parameter int WIDTH = 6
) ();

   logic             start;
   logic [WIDTH-1:0] bias;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] w;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             fire;
   logic             sat;

   modport master (
      output start,
      output bias,
      output in_valid,
      output x,
      output w,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  result,
      input  fire,
      input  sat
   );

   modport slave (
      input  start,
      input  bias,
      input  in_valid,
      input  x,
      input  w,
      input  out_ready,
      output in_ready,
      output out_valid,
      output result,
      output fire,
      output sat
   );

endinterface

// File: rtl/perceptron_mac.sv
// Sequential signed fixed-point multiply-accumulate neuron.
// Streams N_INPUTS (x, w) pairs into a wide accumulator preloaded with the
// bias, then normalises back to Q(WIDTH-FRAC).FRAC, saturates and applies
// the activation selected by ACT (0 identity, 1 ReLU, 2 step).
// The accumulator is sized so that it can never overflow internally:
// each product needs 2*WIDTH bits, summing N_INPUTS of them plus the
// shifted bias needs clog2(N_INPUTS+1) more, and one guard bit is added.
module perceptron_mac #(
   parameter int WIDTH    = 6,
   parameter int FRAC     = 3,
   parameter int N_INPUTS = 4,
   parameter int ACT      = 0
) (
   input logic             clk,
   input logic             reset,
   perceptron_mac_if.slave bus
);

   localparam int PROD_W = 2 * WIDTH;
   localparam int ACC_W  = 2 * WIDTH + $clog2(N_INPUTS + 1) + 1;
   localparam int CNT_W  = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

   // Representable result range, expressed at accumulator width so the
   // comparisons below are done on the full normalised sum.
   localparam logic signed [ACC_W-1:0] SAT_MAX =
      {{(ACC_W - WIDTH + 1){1'b0}}, {(WIDTH - 1){1'b1}}};
   localparam logic signed [ACC_W-1:0] SAT_MIN =
      {{(ACC_W - WIDTH + 1){1'b1}}, {(WIDTH - 1){1'b0}}};

   // 1.0 in the output fixed-point format, used by the step activation.
   localparam logic [WIDTH-1:0] STEP_ONE = {{(WIDTH - 1){1'b0}}, 1'b1} << FRAC;

   localparam logic [1:0] ACT_SEL = ACT[1:0];

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_NORM  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   // Clamp a normalised sum into the WIDTH-bit signed range.
   // Returns {saturated_flag, clamped_value}.
   function automatic logic [WIDTH:0] clamp_fn(input logic signed [ACC_W-1:0] v);
      logic [WIDTH:0] r;
      if (v > SAT_MAX) begin
         r = {1'b1, SAT_MAX[WIDTH-1:0]};
      end else if (v < SAT_MIN) begin
         r = {1'b1, SAT_MIN[WIDTH-1:0]};
      end else begin
         r = {1'b0, v[WIDTH-1:0]};
      end
      return r;
   endfunction

   // Registered state and outputs.
   state_t                   state_r;
   logic signed [ACC_W-1:0]  acc_r;
   logic [CNT_W-1:0]         count_r;
   logic                     in_ready_r;
   logic                     out_valid_r;
   logic [WIDTH-1:0]         result_r;
   logic                     fire_r;
   logic                     sat_r;

   // Combinational datapath.
   logic                     beat_s;
   logic [PROD_W-1:0]        x_ext_s;
   logic [PROD_W-1:0]        w_ext_s;
   logic signed [PROD_W-1:0] prod_s;
   logic signed [ACC_W-1:0]  prod_ext_s;
   logic signed [ACC_W-1:0]  bias_ext_s;
   logic signed [ACC_W-1:0]  shifted_s;
   logic [WIDTH:0]           clamp_s;
   logic [WIDTH-1:0]         clamped_s;
   logic                     sat_s;
   logic                     fire_s;
   logic [WIDTH-1:0]         act_s;

   // Beat qualification, full-width signed product and sign-extended bias.
   always_comb begin
      beat_s     = bus.in_valid & in_ready_r;
      x_ext_s    = {{WIDTH{bus.x[WIDTH-1]}}, bus.x};
      w_ext_s    = {{WIDTH{bus.w[WIDTH-1]}}, bus.w};
      prod_s     = $signed(x_ext_s) * $signed(w_ext_s);
      prod_ext_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
      bias_ext_s = {{(ACC_W - WIDTH){bus.bias[WIDTH-1]}}, bus.bias};
   end

   // Normalise (floor shift), saturate and decide whether the neuron fires.
   always_comb begin
      shifted_s = acc_r >>> FRAC;
      clamp_s   = clamp_fn(shifted_s);
      sat_s     = clamp_s[WIDTH];
      clamped_s = clamp_s[WIDTH-1:0];
      fire_s    = (~shifted_s[ACC_W-1]) & (shifted_s != {ACC_W{1'b0}});
   end

   // Activation selected at elaboration time.
   always_comb begin
      act_s = clamped_s;
      case (ACT_SEL)
         2'd0: begin
            act_s = clamped_s;
         end
         2'd1: begin
            if (clamped_s[WIDTH-1]) begin
               act_s = {WIDTH{1'b0}};
            end else begin
               act_s = clamped_s;
            end
         end
         2'd2: begin
            if (fire_s) begin
               act_s = STEP_ONE;
            end else begin
               act_s = {WIDTH{1'b0}};
            end
         end
         default: begin
            act_s = clamped_s;
         end
      endcase
   end

   // Evaluation sequencer: IDLE -> ACCUM -> NORM -> DONE -> IDLE.
   // A reset anywhere discards the partial sum and clears the outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= ST_IDLE;
         acc_r       <= {ACC_W{1'b0}};
         count_r     <= {CNT_W{1'b0}};
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= {WIDTH{1'b0}};
         fire_r      <= 1'b0;
         sat_r       <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               // The bias only lives on in the preloaded accumulator.
               if (bus.start) begin
                  acc_r      <= bias_ext_s <<< FRAC;
                  count_r    <= {CNT_W{1'b0}};
                  in_ready_r <= 1'b1;
                  state_r    <= ST_ACCUM;
               end
            end
            ST_ACCUM: begin
               if (beat_s) begin
                  acc_r   <= acc_r + prod_ext_s;
                  count_r <= count_r + CNT_W'(1);
                  if (count_r == LAST_CNT) begin
                     in_ready_r <= 1'b0;
                     state_r    <= ST_NORM;
                  end
               end
            end
            ST_NORM: begin
               result_r    <= act_s;
               fire_r      <= fire_s;
               sat_r       <= sat_s;
               out_valid_r <= 1'b1;
               state_r     <= ST_DONE;
            end
            ST_DONE: begin
               // result/fire/sat are left untouched so they persist in IDLE.
               if (bus.out_ready) begin
                  out_valid_r <= 1'b0;
                  state_r     <= ST_IDLE;
               end
            end
            default: begin
               in_ready_r  <= 1'b0;
               out_valid_r <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_r;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;
   assign bus.fire      = fire_r;
   assign bus.sat       = sat_r;

endmodule

// File: tb/tb_perceptron_mac.sv
// Directed bench for perceptron_mac (WIDTH=6, FRAC=3, N_INPUTS=4).
// Three instances (identity, ReLU, step) receive identical stimulus so each
// vector checks all activations at once.
module tb_perceptron_mac;

   logic       clk;
   logic       reset;
   logic       start;
   logic       in_valid;
   logic       out_ready;
   logic [5:0] bias;
   logic [5:0] x;
   logic [5:0] w;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [5:0]       bias;
      logic [3:0][5:0]  x;
      logic [3:0][5:0]  w;
      logic [5:0]       r0;
      logic [5:0]       r1;
      logic [5:0]       r2;
      logic             fire;
      logic             sat;
      int               gap;
      int               stall;
   } vec_t;

   vec_t vecs[12];

   perceptron_mac_if #(.WIDTH(6)) if0 ();
   perceptron_mac_if #(.WIDTH(6)) if1 ();
   perceptron_mac_if #(.WIDTH(6)) if2 ();

   assign if0.start = start;  assign if1.start = start;  assign if2.start = start;
   assign if0.bias  = bias;   assign if1.bias  = bias;   assign if2.bias  = bias;
   assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
   assign if0.x = x; assign if1.x = x; assign if2.x = x;
   assign if0.w = w; assign if1.w = w; assign if2.w = w;
   assign if0.out_ready = out_ready; assign if1.out_ready = out_ready; assign if2.out_ready = out_ready;

   perceptron_mac #(.WIDTH(6), .FRAC(3), .N_INPUTS(4), .ACT(0)) dut0 (
      .clk(clk), .reset(reset), .bus(if0.slave));
   perceptron_mac #(.WIDTH(6), .FRAC(3), .N_INPUTS(4), .ACT(1)) dut1 (
      .clk(clk), .reset(reset), .bus(if1.slave));
   perceptron_mac #(.WIDTH(6), .FRAC(3), .N_INPUTS(4), .ACT(2)) dut2 (
      .clk(clk), .reset(reset), .bus(if2.slave));

   // 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case the sequence ever wedges.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic vec_t mk(input int b, input int x0, input int x1, input int x2,
                               input int x3, input int w0, input int w1, input int w2,
                               input int w3, input int r0, input int r1, input int r2,
                               input int f, input int s, input int gap, input int stall);
      vec_t v;
      v.bias  = 6'(b);
      v.x[0]  = 6'(x0); v.x[1] = 6'(x1); v.x[2] = 6'(x2); v.x[3] = 6'(x3);
      v.w[0]  = 6'(w0); v.w[1] = 6'(w1); v.w[2] = 6'(w2); v.w[3] = 6'(w3);
      v.r0    = 6'(r0);
      v.r1    = 6'(r1);
      v.r2    = 6'(r2);
      v.fire  = 1'(f);
      v.sat   = 1'(s);
      v.gap   = gap;
      v.stall = stall;
      return v;
   endfunction

   task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)",
                  name, $signed(act), act, $signed(exp), exp);
      end
   endtask

   task automatic check_results(input vec_t v, input string tag);
      check({tag, " result act0"}, if0.result, v.r0);
      check({tag, " result act1"}, if1.result, v.r1);
      check({tag, " result act2"}, if2.result, v.r2);
      check({tag, " fire"}, {5'd0, if0.fire}, {5'd0, v.fire});
      check({tag, " fire act2"}, {5'd0, if2.fire}, {5'd0, v.fire});
      check({tag, " sat"}, {5'd0, if0.sat}, {5'd0, v.sat});
   endtask

   // One full evaluation: start, four beats (optional random gaps with
   // junk data and stray start pulses), latency check, optional output
   // stall with stray starts, handshake with a start in the same cycle.
   task automatic run_eval(input vec_t v, input string tag);
      int t;
      int g;
      @(negedge clk);
      start = 1'b1; bias = v.bias; in_valid = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         g = (v.gap > 0) ? int'($urandom_range(0, v.gap)) : 0;
         for (int k = 0; k < g; k++) begin
            in_valid = 1'b0; x = 6'h15; w = 6'h2A; start = (k == 0);
            @(negedge clk);
         end
         start = 1'b0;
         t = 0;
         while (!if0.in_ready && t < 8) begin
            @(negedge clk);
            t++;
         end
         if (!if0.in_ready) begin
            checks++; failures++;
            $display("FAIL %s in_ready wait: got 0 expected 1", tag);
         end
         in_valid = 1'b1; x = v.x[i]; w = v.w[i];
         @(negedge clk);
      end
      in_valid = 1'b0; x = 6'h3F; w = 6'h3F;
      check({tag, " out_valid one cycle after last beat"}, {5'd0, if0.out_valid}, 6'd0);
      check({tag, " in_ready after last beat"}, {5'd0, if0.in_ready}, 6'd0);
      @(negedge clk);
      check({tag, " out_valid two cycles after last beat"}, {5'd0, if0.out_valid}, 6'd1);
      check_results(v, tag);
      for (int s = 0; s < v.stall; s++) begin
         start = (s == 1);
         @(negedge clk);
      end
      start = 1'b0;
      if (v.stall > 0) begin
         check({tag, " out_valid held in stall"}, {5'd0, if0.out_valid}, 6'd1);
         check({tag, " in_ready in stall"}, {5'd0, if0.in_ready}, 6'd0);
         check_results(v, {tag, " stalled"});
      end
      out_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      out_ready = 1'b0; start = 1'b0;
      check({tag, " out_valid after handshake"}, {5'd0, if0.out_valid}, 6'd0);
      @(negedge clk);
      check({tag, " start in handshake ignored"}, {5'd0, if0.in_ready}, 6'd0);
      check({tag, " result persists act0"}, if0.result, v.r0);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      bias = 6'd0; x = 6'd0; w = 6'd0;

      //          bias  x0  x1  x2  x3   w0  w1  w2  w3   r0  r1 r2 f s gap stall
      vecs[0]  = mk(0,   8,  8,  0,  0,   4,  4,  5,  7,   8,  8, 8, 1,0, 0, 0);
      vecs[1]  = mk(0,   8,  8,  8,  8,   8,  8,  8,  8,  31, 31, 8, 1,1, 0, 0);
      vecs[2]  = mk(0,   8,  8,  8,  8,  -8, -8, -8, -8, -32,  0, 0, 0,0, 0, 0);
      vecs[3]  = mk(-1,  1,  1,  1,  1,   1,  1,  1,  1,  -1,  0, 0, 0,0, 0, 0);
      vecs[4]  = mk(1,   0,  0,  0,  0,   5,  5,  5,  5,   1,  1, 8, 1,0, 0, 0);
      vecs[5]  = mk(0,   0,  0,  0,  0,   5,  5,  5,  5,   0,  0, 0, 0,0, 0, 0);
      vecs[6]  = mk(-4, 31, 31, 31, 31, -32,-32,-32,-32, -32,  0, 0, 0,1, 0, 0);
      vecs[7]  = mk(0,   3, -2,  0,  0,   5,  4,  0,  0,   0,  0, 0, 0,0, 0, 0);
      vecs[8]  = mk(0,  -3,  0,  0,  0,   3,  0,  0,  0,  -2,  0, 0, 0,0, 0, 0);
      vecs[9]  = mk(31,  0,  0,  0,  0,   0,  0,  0,  0,  31, 31, 8, 1,0, 0, 0);
      vecs[10] = mk(0,   8,  8,  0,  0,   4,  4,  5,  7,   8,  8, 8, 1,0, 3, 5);
      vecs[11] = mk(0,   8,  8,  8,  8,   8,  8,  8,  8,  31, 31, 8, 1,1, 2, 5);

      // Reset state.
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("reset in_ready", {5'd0, if0.in_ready}, 6'd0);
      check("reset out_valid", {5'd0, if0.out_valid}, 6'd0);
      check("reset result", if0.result, 6'd0);
      check("reset fire", {5'd0, if0.fire}, 6'd0);
      check("reset sat", {5'd0, if0.sat}, 6'd0);

      // Table-driven evaluations.
      for (int i = 0; i < 12; i++) begin
         run_eval(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset mid-ACCUM after two beats.
      @(negedge clk);
      start = 1'b1; bias = 6'd0;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         in_valid = 1'b1; x = 6'd8; w = 6'd8;
         @(negedge clk);
      end
      in_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      check("midreset in_ready", {5'd0, if0.in_ready}, 6'd0);
      check("midreset out_valid", {5'd0, if0.out_valid}, 6'd0);
      check("midreset result act0", if0.result, 6'd0);
      check("midreset result act2", if2.result, 6'd0);
      check("midreset fire", {5'd0, if0.fire}, 6'd0);
      check("midreset sat", {5'd0, if0.sat}, 6'd0);
      run_eval(vecs[0], "after reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
